// File: rtl/pll_supervisor.sv
// PLL lock supervisor and staggered reset sequencer (reference-clock domain).
// Define PLLSUP_LOSS_CNT_EN to add the 16-bit loss_cnt output.
module pll_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int NRST          = 2,
  parameter int STAGGER       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pll_lock,
  output logic            pll_rst,
  output logic [NRST-1:0] rst_out,
  output logic            locked,
  output logic            fail,
`ifdef PLLSUP_LOSS_CNT_EN
  output logic [15:0]     loss_cnt,
`endif
  output logic [7:0]      retry_cnt
);

  localparam int REL_SPAN = (NRST - 1) * STAGGER;
  localparam int SEQ_MAX  =
    (RST_CYCLES > REL_SPAN) ? RST_CYCLES : REL_SPAN;
  localparam int SEQ_W = $clog2(SEQ_MAX + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [SEQ_W-1:0] SEQ_LIM  = SEQ_W'(SEQ_MAX);
  localparam logic [SEQ_W-1:0] RST_LAST = SEQ_W'(RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] REL_LAST = SEQ_W'(REL_SPAN);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0] STB_LIM  = STB_W'(STABLE_CYCLES);
  localparam logic [7:0]       MAX_R    = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAIL
  } state_e;

  state_e           state_q, state_d;
  logic             meta_q, lock_s_q;
  logic [SEQ_W-1:0] seq_q, seq_d, seq_inc;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [STB_W-1:0] stb_q, stb_d, stb_inc;
  logic             pll_rst_q, pll_rst_d;
  logic [NRST-1:0]  rst_out_q, rst_out_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic [7:0]       retry_q, retry_d, retry_inc;
  logic             lost;
`ifdef PLLSUP_LOSS_CNT_EN
  logic [15:0]      loss_q, loss_d;
`endif

  // Bit i stays in reset until the release counter reaches i*STAGGER.
  function automatic logic [NRST-1:0] stag(input logic [SEQ_W-1:0] c);
    logic [NRST-1:0] m;
    m = '1;
    for (int i = 0; i < NRST; i++) begin
      m[i] = c < SEQ_W'(i * STAGGER);
    end
    return m;
  endfunction

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    tmo_d     = tmo_q;
    stb_d     = stb_q;
    pll_rst_d = pll_rst_q;
    rst_out_d = rst_out_q;
    locked_d  = locked_q;
    fail_d    = fail_q;
    retry_d   = retry_q;
`ifdef PLLSUP_LOSS_CNT_EN
    loss_d    = loss_q;
`endif
    seq_inc   = (seq_q == SEQ_LIM) ? seq_q : seq_q + SEQ_W'(1);
    tmo_inc   = (tmo_q == TMO_LIM) ? tmo_q : tmo_q + TMO_W'(1);
    stb_inc   = (stb_q == STB_LIM) ? stb_q : stb_q + STB_W'(1);
    retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    lost      = !lock_s_q &&
                (state_q == RELEASE || state_q == RUN);

    unique case (state_q)
      RESET_PLL: begin
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        locked_d  = 1'b0;
        seq_d     = seq_inc;
        if (seq_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
          seq_d     = '0;
          tmo_d     = '0;
          stb_d     = '0;
        end
      end
      WAIT_LOCK: begin
        tmo_d = tmo_inc;
        stb_d = lock_s_q ? stb_inc : '0;
        if (stb_d == STB_LIM) begin
          retry_d   = '0;
          seq_d     = '0;
          rst_out_d = stag('0);
          if (REL_LAST == '0) begin
            state_d  = RUN;
            locked_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else if (tmo_d == TMO_LIM) begin
          retry_d   = retry_inc;
          pll_rst_d = 1'b1;
          seq_d     = '0;
          if (retry_d == MAX_R) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = RESET_PLL;
          end
        end
      end
      RELEASE: begin
        seq_d     = seq_inc;
        rst_out_d = stag(seq_d);
        if (seq_d == REL_LAST) begin
          state_d  = RUN;
          locked_d = 1'b1;
        end
      end
      RUN: ;
      FAIL: begin
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        locked_d  = 1'b0;
        fail_d    = 1'b1;
      end
      default: state_d = RESET_PLL;
    endcase

    // Lock loss overrides any release progress.
    if (lost) begin
      state_d   = RESET_PLL;
      pll_rst_d = 1'b1;
      rst_out_d = '1;
      locked_d  = 1'b0;
      seq_d     = '0;
`ifdef PLLSUP_LOSS_CNT_EN
      if (loss_q != 16'hFFFF) loss_d = loss_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      meta_q    <= 1'b0;
      lock_s_q  <= 1'b0;
      seq_q     <= '0;
      tmo_q     <= '0;
      stb_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= '0;
`ifdef PLLSUP_LOSS_CNT_EN
      loss_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      meta_q    <= pll_lock;
      lock_s_q  <= meta_q;
      seq_q     <= seq_d;
      tmo_q     <= tmo_d;
      stb_q     <= stb_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
      retry_q   <= retry_d;
`ifdef PLLSUP_LOSS_CNT_EN
      loss_q    <= loss_d;
`endif
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out   = rst_out_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
`ifdef PLLSUP_LOSS_CNT_EN
  assign loss_cnt  = loss_q;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: expected output vectors are queued
// per cycle as stimulus is driven and compared on the falling edge.
module tb_pll_supervisor;
  localparam int RC = 4;
  localparam int TO = 100;
  localparam int SC = 8;
  localparam int MR = 3;
  localparam int NR = 3;
  localparam int SG = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_lock = 1'b0;
  logic          pll_rst;
  logic [NR-1:0] rst_out;
  logic          locked;
  logic          fail;
  logic [7:0]    retry_cnt;
`ifdef PLLSUP_LOSS_CNT_EN
  logic [15:0]   loss_cnt;
`endif
  logic [13:0]   obs;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int prst_hi = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [13:0] exp;
  } exp_t;
  exp_t sb[$];

  pll_supervisor #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .NRST         (NR),
    .STAGGER      (SG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .pll_rst  (pll_rst),
    .rst_out  (rst_out),
    .locked   (locked),
    .fail     (fail),
`ifdef PLLSUP_LOSS_CNT_EN
    .loss_cnt (loss_cnt),
`endif
    .retry_cnt(retry_cnt)
  );

  assign obs = {pll_rst, rst_out, locked, fail, retry_cnt};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [13:0] v(input logic p, input logic [2:0] r,
                                    input logic l, input logic f,
                                    input logic [7:0] rc);
    return {p, r, l, f, rc};
  endfunction

  task automatic exp_at(input int c, input string tag,
                        input logic [13:0] e);
    exp_t x;
    x.cyc = c;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (pll_rst === 1'b1) prst_hi <= prst_hi + 1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      if (sb[0].cyc == cyc) chk(sb[0].tag, 32'(obs), 32'(sb[0].exp));
      else chk({sb[0].tag, "_cyc"}, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 500 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  // One reset edge; returns the cycle of that edge.
  task automatic do_reset(input string tag, output int r);
    pll_lock = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    r = cyc;
    rst = 1'b0;
    exp_at(r, {tag, "_rstv"}, v(1, 3'b111, 0, 0, 8'd0));
    exp_at(r + RC - 1, {tag, "_prst1"}, v(1, 3'b111, 0, 0, 8'd0));
    exp_at(r + RC, {tag, "_prst0"}, v(0, 3'b111, 0, 0, 8'd0));
  endtask

  task automatic release_exp(input string tag, input int e,
                             input logic [7:0] rb);
    exp_at(e - 1, {tag, "_pre"}, v(0, 3'b111, 0, 0, rb));
    exp_at(e,     {tag, "_r0"},  v(0, 3'b110, 0, 0, 8'd0));
    exp_at(e + 1, {tag, "_r0b"}, v(0, 3'b110, 0, 0, 8'd0));
    exp_at(e + 2, {tag, "_r1"},  v(0, 3'b100, 0, 0, 8'd0));
    exp_at(e + 3, {tag, "_r1b"}, v(0, 3'b100, 0, 0, 8'd0));
    exp_at(e + 4, {tag, "_lck"}, v(0, 3'b000, 1, 0, 8'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, p, e, d, f, base;

    // Clean lock
    do_reset("clean", r);
    p = r + RC;
    go_to(p + 5);
    pll_lock = 1'b1;
    e = p + 5 + 2 + SC;
    release_exp("clean", e, 8'd0);
    drain("clean");

    // Loss in RUN, then full re-sequence
    d = cyc;
    exp_at(d + 2, "loss_hold", v(0, 3'b000, 1, 0, 8'd0));
    exp_at(d + 3, "loss_asrt", v(1, 3'b111, 0, 0, 8'd0));
    exp_at(d + 3 + RC - 1, "loss_prst1", v(1, 3'b111, 0, 0, 8'd0));
    exp_at(d + 3 + RC, "loss_prst0", v(0, 3'b111, 0, 0, 8'd0));
    release_exp("reloss", d + 3 + RC + SC, 8'd0);
`ifdef PLLSUP_LOSS_CNT_EN
    chk("loss_cnt0", 32'(loss_cnt), 0);
`endif
    pll_lock = 1'b0;
    go_to(d + 1);
    pll_lock = 1'b1;
    go_to(d + 3);
`ifdef PLLSUP_LOSS_CNT_EN
    chk("loss_cnt1", 32'(loss_cnt), 1);
`endif
    drain("loss");

    // Glitchy lock
    do_reset("glitch", r);
`ifdef PLLSUP_LOSS_CNT_EN
    chk("loss_cnt_rst", 32'(loss_cnt), 0);
`endif
    p = r + RC;
    go_to(p + 5);
    pll_lock = 1'b1;
    go_to(p + 11);
    pll_lock = 1'b0;
    go_to(p + 12);
    pll_lock = 1'b1;
    exp_at(p + 15, "glitch_noearly", v(0, 3'b111, 0, 0, 8'd0));
    release_exp("glitch", p + 12 + 2 + SC, 8'd0);
    drain("glitch");

    // Timeout then lock
    do_reset("tmo", r);
    base = prst_hi;
    p = r + RC;
    exp_at(p + TO - 1, "tmo_wait", v(0, 3'b111, 0, 0, 8'd0));
    exp_at(p + TO, "tmo_retry", v(1, 3'b111, 0, 0, 8'd1));
    exp_at(p + TO + RC - 1, "tmo_p2hi", v(1, 3'b111, 0, 0, 8'd1));
    exp_at(p + TO + RC, "tmo_p2lo", v(0, 3'b111, 0, 0, 8'd1));
    go_to(p + TO + RC + 5);
    pll_lock = 1'b1;
    release_exp("tmo", p + TO + RC + 5 + 2 + SC, 8'd1);
    drain("tmo");
    chk("tmo_prst_cycles", prst_hi - base, 2 * RC);

    // Mid-RELEASE reset
    do_reset("mid", r);
    p = r + RC;
    go_to(p + 5);
    pll_lock = 1'b1;
    e = p + 5 + 2 + SC;
    exp_at(e, "mid_r0", v(0, 3'b110, 0, 0, 8'd0));
    go_to(e);
    do_reset("mid2", r);
    chk("mid_rcyc", r, e + 1);
    drain("mid");

    // Exhaustion
    do_reset("exh", r);
    p = r + RC;
    f = p + MR * TO + (MR - 1) * RC;
    exp_at(p + TO, "exh_r1", v(1, 3'b111, 0, 0, 8'd1));
    exp_at(p + 2 * TO + RC, "exh_r2", v(1, 3'b111, 0, 0, 8'd2));
    exp_at(f - 1, "exh_pre", v(0, 3'b111, 0, 0, 8'd2));
    exp_at(f, "exh_fail", v(1, 3'b111, 0, 1, 8'd3));
    exp_at(f + 20, "exh_sticky", v(1, 3'b111, 0, 1, 8'd3));
    go_to(f + 20);
    do_reset("exh_clr", r);
    drain("exh");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
